// File: rtl/branch_flag_resolver_if.sv
// Request/response bundle between decode, the branch resolver and the PC/fetch stage.
// The master drives branch requests and carry flag state; the slave returns the resolution.
interface branch_flag_resolver_if #(
  parameter int ADDR_W = 32
);
  logic              br_valid;
  logic              ready;
  logic [3:0]        br_op;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] br_target;
  logic [ADDR_W-1:0] rs_val;
  logic              carry_in;
  logic              carry_pending;
  logic              kill;
  logic              npc_valid;
  logic [ADDR_W-1:0] npc;
  logic              taken;
  logic              flush;
  logic              link_we;
  logic [ADDR_W-1:0] link_data;
  logic              illegal;
  logic              misalign;

  modport master (
    output br_valid, br_op, pc, br_target, rs_val, carry_in, carry_pending, kill,
    input  ready, npc_valid, npc, taken, flush, link_we, link_data, illegal, misalign
  );

  modport slave (
    input  br_valid, br_op, pc, br_target, rs_val, carry_in, carry_pending, kill,
    output ready, npc_valid, npc, taken, flush, link_we, link_data, illegal, misalign
  );
endinterface

// File: rtl/branch_flag_resolver.sv
// Resolves one branch at a time, stalling carry-dependent branches until the carry flag
// settles, and presents a registered next-PC / flush / link-write result for one cycle.
module branch_flag_resolver #(
  parameter int ADDR_W   = 32,
  parameter int LINK_INC = 4
) (
  input logic                   clk,
  input logic                   rst,
  branch_flag_resolver_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    EVAL    = 2'd1,
    WAIT_CY = 2'd2,
    RESP    = 2'd3
  } state_t;

  localparam logic [3:0] OP_B    = 4'd0;
  localparam logic [3:0] OP_BR   = 4'd1;
  localparam logic [3:0] OP_BLTZ = 4'd2;
  localparam logic [3:0] OP_BZ   = 4'd3;
  localparam logic [3:0] OP_BNZ  = 4'd4;
  localparam logic [3:0] OP_BL   = 4'd5;
  localparam logic [3:0] OP_BCY  = 4'd6;
  localparam logic [3:0] OP_BNCY = 4'd7;

  state_t            state_q, state_d;
  logic [3:0]        op_q, op_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] tgt_q, tgt_d;
  logic [ADDR_W-1:0] rs_q, rs_d;

  logic [ADDR_W-1:0] npc_q, npc_d;
  logic [ADDR_W-1:0] link_data_q, link_data_d;
  logic              taken_q, taken_d;
  logic              npc_valid_q, npc_valid_d;
  logic              flush_q, flush_d;
  logic              link_we_q, link_we_d;
  logic              illegal_q, illegal_d;
  logic              misalign_q, misalign_d;

  // Combinational resolution of the captured request against the live carry flag.
  logic              res_taken;
  logic [ADDR_W-1:0] res_dest;
  logic [ADDR_W-1:0] res_fall;
  logic [ADDR_W-1:0] res_npc;
  logic              res_misalign;
  logic              res_illegal;
  logic              is_cy_op;
  logic              resolve;

  assign is_cy_op = (op_q == OP_BCY) || (op_q == OP_BNCY);

  always_comb begin
    res_taken   = 1'b0;
    res_illegal = 1'b0;
    res_dest    = (op_q == OP_BR) ? rs_q : tgt_q;
    res_fall    = pc_q + ADDR_W'(LINK_INC);
    case (op_q)
      OP_B, OP_BR, OP_BL: res_taken = 1'b1;
      OP_BLTZ:            res_taken = rs_q[ADDR_W-1];
      OP_BZ:              res_taken = (rs_q == '0);
      OP_BNZ:             res_taken = (rs_q != '0);
      OP_BCY:             res_taken = bus.carry_in;
      OP_BNCY:            res_taken = ~bus.carry_in;
      default:            res_illegal = 1'b1;
    endcase
    res_npc      = res_taken ? {res_dest[ADDR_W-1:2], 2'b00} : res_fall;
    res_misalign = res_taken && (res_dest[1:0] != 2'b00);
  end

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    pc_d        = pc_q;
    tgt_d       = tgt_q;
    rs_d        = rs_q;
    npc_d       = npc_q;
    link_data_d = link_data_q;
    taken_d     = taken_q;
    npc_valid_d = 1'b0;
    flush_d     = 1'b0;
    link_we_d   = 1'b0;
    illegal_d   = 1'b0;
    misalign_d  = 1'b0;
    resolve     = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.br_valid) begin
          op_d    = bus.br_op;
          pc_d    = bus.pc;
          tgt_d   = bus.br_target;
          rs_d    = bus.rs_val;
          state_d = EVAL;
        end
      end
      EVAL: begin
        if (bus.kill) begin
          state_d = IDLE;
        end else if (is_cy_op && bus.carry_pending) begin
          state_d = WAIT_CY;
        end else begin
          resolve = 1'b1;
        end
      end
      WAIT_CY: begin
        if (bus.kill) begin
          state_d = IDLE;
        end else if (!bus.carry_pending) begin
          resolve = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (resolve) begin
      state_d     = RESP;
      npc_d       = res_npc;
      link_data_d = res_fall;
      taken_d     = res_taken;
      npc_valid_d = 1'b1;
      flush_d     = res_taken;
      link_we_d   = (op_q == OP_BL);
      illegal_d   = res_illegal;
      misalign_d  = res_misalign;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      op_q        <= '0;
      pc_q        <= '0;
      tgt_q       <= '0;
      rs_q        <= '0;
      npc_q       <= '0;
      link_data_q <= '0;
      taken_q     <= 1'b0;
      npc_valid_q <= 1'b0;
      flush_q     <= 1'b0;
      link_we_q   <= 1'b0;
      illegal_q   <= 1'b0;
      misalign_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      pc_q        <= pc_d;
      tgt_q       <= tgt_d;
      rs_q        <= rs_d;
      npc_q       <= npc_d;
      link_data_q <= link_data_d;
      taken_q     <= taken_d;
      npc_valid_q <= npc_valid_d;
      flush_q     <= flush_d;
      link_we_q   <= link_we_d;
      illegal_q   <= illegal_d;
      misalign_q  <= misalign_d;
    end
  end

  assign bus.ready     = (state_q == IDLE);
  assign bus.npc_valid = npc_valid_q;
  assign bus.npc       = npc_q;
  assign bus.taken     = taken_q;
  assign bus.flush     = flush_q;
  assign bus.link_we   = link_we_q;
  assign bus.link_data = link_data_q;
  assign bus.illegal   = illegal_q;
  assign bus.misalign  = misalign_q;

endmodule

// File: tb/tb_branch_flag_resolver.sv
// Directed and randomized checks of branch_flag_resolver against a spec-level reference
// model of branch outcome, latency, pulse shape, kill and reset behaviour.
module tb_branch_flag_resolver;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  branch_flag_resolver_if #(.ADDR_W(32)) bus ();

  branch_flag_resolver #(.ADDR_W(32), .LINK_INC(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] npc;
    logic        taken;
    logic        flush;
    logic        link_we;
    logic [31:0] link_data;
    logic        illegal;
    logic        misalign;
  } exp_t;

  // Outcome straight from the branch rules: condition table, 4-byte fall-through, word-aligned target.
  function automatic exp_t model(int unsigned op, logic [31:0] pc, logic [31:0] tgt,
                                 logic [31:0] rs, logic cy);
    exp_t            e;
    longint unsigned fall;
    logic [31:0]     dest;
    bit              tk;
    fall = longint'(pc) + 64'd4;
    dest = (op == 1) ? rs : tgt;
    tk   = (op == 0) || (op == 1) || (op == 5) ||
           (op == 2 && $signed(rs) < 0) ||
           (op == 3 && rs == 0) || (op == 4 && rs != 0) ||
           (op == 6 && cy) || (op == 7 && !cy);
    e.npc       = tk ? (dest / 4) * 4 : fall[31:0];
    e.taken     = tk;
    e.flush     = tk;
    e.link_we   = (op == 5);
    e.link_data = fall[31:0];
    e.illegal   = (op >= 8);
    e.misalign  = tk && (dest % 4 != 0);
    return e;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [4:0] pulses();
    return {bus.npc_valid, bus.flush, bus.link_we, bus.illegal, bus.misalign};
  endfunction

  // One full request: accept, optional carry stall, response check, then post-response check.
  task automatic run_branch(string tag, int unsigned op, logic [31:0] pc, logic [31:0] tgt,
                            logic [31:0] rs, logic final_cy, int pend, bit toggle);
    exp_t e;
    int   lat;
    int   waits;
    bit   got;
    e     = model(op, pc, tgt, rs, final_cy);
    waits = (op == 6 || op == 7) ? pend : 0;
    chk({tag, ":ready_before"}, 32'(bus.ready), 32'd1);
    bus.br_op     = op[3:0];
    bus.pc        = pc;
    bus.br_target = tgt;
    bus.rs_val    = rs;
    bus.br_valid  = 1'b1;
    step();
    bus.br_valid = 1'b0;
    lat = 0;
    got = 1'b0;
    for (int k = 1; k <= 20 && !got; k++) begin
      bus.carry_pending = (k <= pend);
      bus.carry_in      = (k <= pend && toggle) ? 1'($urandom) : final_cy;
      step();
      if (bus.npc_valid) begin
        got = 1'b1;
        lat = k + 1;
      end
    end
    bus.carry_pending = 1'b0;
    chk({tag, ":latency"}, 32'(lat), 32'(2 + waits));
    chk({tag, ":npc"}, bus.npc, e.npc);
    chk({tag, ":taken"}, 32'(bus.taken), 32'(e.taken));
    chk({tag, ":flush"}, 32'(bus.flush), 32'(e.flush));
    chk({tag, ":link_we"}, 32'(bus.link_we), 32'(e.link_we));
    chk({tag, ":link_data"}, bus.link_data, e.link_data);
    chk({tag, ":illegal"}, 32'(bus.illegal), 32'(e.illegal));
    chk({tag, ":misalign"}, 32'(bus.misalign), 32'(e.misalign));
    chk({tag, ":ready_resp"}, 32'(bus.ready), 32'd0);
    step();
    chk({tag, ":pulses_after"}, 32'(pulses()), 32'd0);
    chk({tag, ":ready_after"}, 32'(bus.ready), 32'd1);
    chk({tag, ":npc_hold"}, bus.npc, e.npc);
    chk({tag, ":link_hold"}, bus.link_data, e.link_data);
    $display("txn %s op=%0d pc=%h tgt=%h rs=%h cy=%0d pend=%0d -> npc=%h taken=%0d lat=%0d",
             tag, op, pc, tgt, rs, final_cy, pend, e.npc, e.taken, lat);
  endtask

  initial begin
    n_checks          = 0;
    n_fail            = 0;
    rst               = 1'b1;
    bus.br_valid      = 1'b0;
    bus.br_op         = '0;
    bus.pc            = '0;
    bus.br_target     = '0;
    bus.rs_val        = '0;
    bus.carry_in      = 1'b0;
    bus.carry_pending = 1'b0;
    bus.kill          = 1'b0;
    step();
    step();
    chk("reset:ready", 32'(bus.ready), 32'd1);
    chk("reset:pulses", 32'(pulses()), 32'd0);
    chk("reset:npc", bus.npc, 32'd0);
    chk("reset:link_data", bus.link_data, 32'd0);
    chk("reset:taken", 32'(bus.taken), 32'd0);
    rst = 1'b0;
    step();

    run_branch("bz_zero", 3, 32'h100, 32'h200, 32'h0, 1'b0, 0, 1'b0);
    run_branch("bz_nonzero", 3, 32'h100, 32'h200, 32'h5, 1'b0, 0, 1'b0);
    run_branch("bcy_wait", 6, 32'h400, 32'h1000, 32'h0, 1'b1, 3, 1'b1);
    run_branch("bncy_wait", 7, 32'h400, 32'h1000, 32'h0, 1'b1, 2, 1'b1);
    run_branch("bl_wrap", 5, 32'hFFFF_FFFC, 32'h0000_8000, 32'h0, 1'b0, 0, 1'b0);
    run_branch("br_misalign", 1, 32'h50, 32'h0, 32'h303, 1'b0, 0, 1'b0);
    run_branch("illegal9", 9, 32'h800, 32'h900, 32'h1, 1'b1, 0, 1'b0);
    run_branch("bltz_neg", 2, 32'h10, 32'h22, 32'h8000_0000, 1'b0, 0, 1'b0);
    run_branch("b_pend_ignored", 0, 32'h10, 32'h44, 32'h0, 1'b0, 3, 1'b1);

    // kill in EVAL
    bus.br_op = 4'd0; bus.pc = 32'h20; bus.br_target = 32'h40; bus.br_valid = 1'b1;
    step();
    bus.br_valid = 1'b0;
    bus.kill     = 1'b1;
    step();
    bus.kill = 1'b0;
    chk("kill_eval:ready", 32'(bus.ready), 32'd1);
    chk("kill_eval:pulses", 32'(pulses()), 32'd0);
    step();
    chk("kill_eval:pulses2", 32'(pulses()), 32'd0);
    $display("txn kill_eval");

    // kill in WAIT_CY, together with carry_pending
    bus.br_op = 4'd6; bus.br_valid = 1'b1;
    step();
    bus.br_valid      = 1'b0;
    bus.carry_pending = 1'b1;
    step();
    chk("kill_wait:in_wait", 32'(bus.ready), 32'd0);
    bus.kill = 1'b1;
    step();
    bus.kill          = 1'b0;
    bus.carry_pending = 1'b0;
    chk("kill_wait:ready", 32'(bus.ready), 32'd1);
    chk("kill_wait:pulses", 32'(pulses()), 32'd0);
    step();
    chk("kill_wait:pulses2", 32'(pulses()), 32'd0);
    $display("txn kill_wait");

    // br_valid held through EVAL: only one response
    bus.br_op = 4'd3; bus.pc = 32'h300; bus.br_target = 32'h500; bus.rs_val = 32'h0;
    bus.br_valid = 1'b1;
    step();
    step();
    chk("hold_valid:resp", 32'(bus.npc_valid), 32'd1);
    chk("hold_valid:npc", bus.npc, 32'h500);
    bus.br_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      chk($sformatf("hold_valid:no_second%0d", k), 32'(bus.npc_valid), 32'd0);
    end
    chk("hold_valid:ready", 32'(bus.ready), 32'd1);
    $display("txn hold_valid");

    // reset held two cycles while stalled on the carry flag
    bus.br_op = 4'd7; bus.br_valid = 1'b1;
    step();
    bus.br_valid      = 1'b0;
    bus.carry_pending = 1'b1;
    step();
    rst = 1'b1;
    step();
    step();
    rst               = 1'b0;
    bus.carry_pending = 1'b0;
    chk("rst_wait:ready", 32'(bus.ready), 32'd1);
    chk("rst_wait:pulses", 32'(pulses()), 32'd0);
    chk("rst_wait:npc", bus.npc, 32'd0);
    chk("rst_wait:link_data", bus.link_data, 32'd0);
    step();
    step();
    chk("rst_wait:no_resp", 32'(pulses()), 32'd0);
    $display("txn rst_wait");

    for (int i = 0; i < 40; i++) begin
      run_branch($sformatf("rnd%0d", i), $urandom_range(0, 15), $urandom, $urandom,
                 ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom, 1'($urandom),
                 $urandom_range(0, 3), 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/branch_flag_resolver.md
# branch_flag_resolver

Reader-side consumer of the processor's carry flag. Accepts one branch request from decode, waits out any in-flight carry update from the ALU, evaluates the branch condition from the flag and the source operand, then returns a registered next-PC, taken/flush indication and link-register write for `bl`. It sits between decode and the PC/fetch stage, alongside the carry flag register it reads.

## Interface
- `ADDR_W`, 32: width of PC, target, operand and link data.
- `LINK_INC`, 4: increment added to `pc` for the fall-through and link address.
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `br_valid`  in  1  branch request present.
- `ready`  out  1  block can accept a request; high only in IDLE.
- `br_op`  in  4  0 b, 1 br, 2 bltz, 3 bz, 4 bnz, 5 bl, 6 bcy, 7 bncy, 8–15 illegal.
- `pc`  in  ADDR_W  address of the branch instruction.
- `br_target`  in  ADDR_W  immediate target (ops 0, 2–7).
- `rs_val`  in  ADDR_W  source register value (condition for 2–4; target for op 1).
- `carry_in`  in  1  current value of the carry flag register.
- `carry_pending`  in  1  an ALU carry write is still in flight; flag is stale.
- `kill`  in  1  squash the in-flight request.
- `npc_valid`  out  1  one-cycle pulse, result valid.
- `npc`  out  ADDR_W  next PC.
- `taken`  out  1  branch taken (qualified by `npc_valid`).
- `flush`  out  1  one-cycle pulse, equal to `npc_valid & taken`.
- `link_we`  out  1  one-cycle pulse, write `link_data` to r31.
- `link_data`  out  ADDR_W  `pc + LINK_INC`.
- `illegal`  out  1  one-cycle pulse, illegal `br_op` resolved.
- `misalign`  out  1  one-cycle pulse, taken target had bits [1:0] nonzero.

## Operation
- States: IDLE, EVAL, WAIT_CY, RESP.
- IDLE: `ready`=1. If `br_valid`: capture `br_op`, `pc`, `br_target`, `rs_val`; go to EVAL. Otherwise stay.
- EVAL: if `kill`, go to IDLE with no response. Else if op ∈ {6, 7} and `carry_pending`, go to WAIT_CY. Else resolve and go to RESP.
- WAIT_CY: if `kill`, go to IDLE. Else if `!carry_pending`, resolve and go to RESP. Else stay; there is no timeout.
- Resolve: sample `carry_in` at the resolving edge, and register all outputs at that same edge.
- RESP: outputs are asserted for exactly this cycle, then the block returns to IDLE. `kill` in RESP has no effect.
- Conditions:
  - b, bl: always taken.
  - br: taken, target = captured `rs_val`.
  - bltz: `rs_val[31]`=1.
  - bz: `rs_val`==0.
  - bnz: `rs_val`!=0.
  - bcy: `carry_in`=1.
  - bncy: `carry_in`=0.
  - illegal: not taken, `illegal`=1.
- `npc` = taken ? {target[ADDR_W-1:2], 2'b00} : `pc`+`LINK_INC`. Addition is modulo 2^ADDR_W (wraps). `misalign`=1 iff taken and target[1:0]!=0.
- `link_we`=1 only for bl. `link_data` is always `pc`+`LINK_INC`.
- `br_valid` outside IDLE is ignored and not queued.
- Reset in any state: go to IDLE and clear the captured registers.

## Timing
- Reset values: `ready`=1 (IDLE), all other outputs 0, `npc`=0, `link_data`=0.
- Request accepted at edge N, EVAL is cycle N+1, RESP (outputs valid) is cycle N+2.
- Best-case latency is 2 cycles, and throughput is one branch per 3 cycles.
- Each cycle spent in WAIT_CY adds one cycle. The result appears in the cycle after the first edge where `carry_pending`=0.
- Outside RESP, all pulse outputs are 0. `npc`, `taken` and `link_data` hold their last values.
- `kill` together with `carry_pending`: `kill` wins.

## Test plan
- Reset: hold `rst` 2 cycles mid-WAIT_CY. Required: IDLE, `ready`=1, all pulses 0, `npc`=0.
- bz with `pc`=0x100, `br_target`=0x200, `rs_val`=0: `npc`=0x200, `taken`=1, `flush`=1 at N+2. Repeat with `rs_val`=5: `npc`=0x104, `taken`=0, `flush`=0.
- bcy with `carry_pending`=1 for 3 cycles, then 0, `carry_in`=1 on release: response 5 cycles after accept with `npc`=target, `taken`=1. Toggling `carry_in` during the wait must not matter.
- bl with `pc`=0xFFFFFFFC: `link_we`=1, `link_data`=0x0 (wrap), `npc`=target.
- br with `rs_val`=0x303: `npc`=0x300, `misalign`=1. `br_op`=9: `illegal`=1, `taken`=0, `npc`=`pc`+4.
- `kill` in EVAL and in WAIT_CY: no `npc_valid` pulse, `ready`=1 next cycle. `br_valid` held high during EVAL: only one request is accepted.
